multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the 16-bit MiniMIPS datapath. It replaces single-cycle main control with a Moore FSM that splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps.
- Instruction and data memory are reached through a ready handshake, so a slow memory stalls the FSM instead of corrupting state.
- The block drives every datapath enable and mux select, and counts retired instructions.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  level; leaves IDLE and starts fetching when 1.
- opcode  in  4  IR[15:12] of the instruction latched in the datapath IR.
- zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completed current read/write this cycle.
- pc_write  out  1  load PC this cycle.
- pc_src  out  1  0 = PC+1, 1 = PC+1+sext(imm6) (from old-PC register).
- ir_write  out  1  latch fetched instruction into IR.
- imem_read  out  1  instruction-fetch request.
- dmem_read  out  1  data read request.
- dmem_write  out  1  data write request.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  1 = rd IR[5:3], 0 = rt IR[8:6].
- alu_src  out  1  0 = rt, 1 = sext(imm6).
- mem_to_reg  out  1  1 = write-back from data memory.
- alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 111 use funct IR[2:0].
- state_o  out  4  current state encoding, for debug.
- illegal  out  1  sticky; an undefined opcode was decoded.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Opcode map: 0000 R-type, 0001 addi, 0010 andi, 0011 ori, 0100 slti, 0101 lw, 0110 sw, 0111 beq, 1000 bne, 1111 halt. All other opcodes are illegal.
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, HALT.
- Outputs are Moore-decoded from the state register, except pc_write/ir_write in FETCH and pc_write in BRANCH. Every output is 0 whenever not asserted below.
- Reset (asynchronous, any state, mid-instruction included): state = IDLE, retired = 0, illegal = 0. All outputs read 0 while reset_n = 0.
- IDLE: if run = 1, go to FETCH, else stay.
- FETCH: imem_read = 1. When mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, go to DECODE. Otherwise stay, with no PC/IR update.
- DECODE: alu_op = add. Transitions by opcode:
  - R → EXEC_R
  - addi/andi/ori/slti → EXEC_I
  - lw/sw → MEM_ADDR
  - beq/bne → BRANCH
  - halt → HALT
  - illegal → HALT, setting illegal.
- EXEC_R: alu_src = 0, alu_op = 111 → WB_R.
- EXEC_I: alu_src = 1, alu_op per opcode (add/and/or/slt) → WB_I.
- WB_R: the EXEC_R ALU controls are held, plus reg_write = 1, reg_dst = 1.
- WB_I: the EXEC_I ALU controls are held, plus reg_write = 1, reg_dst = 0.
- MEM_ADDR: alu_src = 1, alu_op = add. Go to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: address controls held, dmem_read = 1. Wait for mem_ready, then go to WB_MEM.
- MEM_WR: address controls held, dmem_write = 1. Wait for mem_ready, then retire and go to FETCH.
- WB_MEM: reg_write = 1, reg_dst = 0, mem_to_reg = 1.
- BRANCH: alu_src = 0, alu_op = sub, pc_src = 1.
  - pc_write = 1 if (beq & zero) or (bne & !zero).
  - Retire and go to FETCH.
- WB_R, WB_I, WB_MEM retire and go to FETCH.
- Retire: retired increments by 1 on the edge that leaves the final state, and wraps from all-ones to 0. halt and illegal do not retire.
- run is sampled only in IDLE; deasserting it mid-program has no effect.
- HALT: all enables 0. Stay until reset.
- Latencies with mem_ready tied high:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - Each memory wait cycle adds 1.
- dmem_read and dmem_write are never both 1. imem_read never overlaps either.

Decomposition:
- Shared package:
  - opcode constants
  - alu_op codes
  - 4-bit state encoding: IDLE = 0, FETCH = 1, … HALT = 12, in listed order
- Natural sub-module: control_decode, a pure combinational map of state + opcode + zero to the control vector. Keeps the FSM next-state logic separate.

Test Plan:
- Reset mid-MEM_RD with dmem_read = 1: reset_n low → state_o = 0 and all outputs 0 immediately. After release with run = 0, stays in IDLE.
- run = 1, opcode = 0000, mem_ready = 1: state sequence FETCH, DECODE, EXEC_R, WB_R, FETCH. reg_write = 1 only in WB_R, with reg_dst = 1. retired goes 0 → 1.
- lw (0101) with mem_ready held low 3 cycles in MEM_RD: dmem_read held 4 cycles. WB_MEM has mem_to_reg = 1, reg_write = 1. 8 cycles from FETCH entry back to FETCH.
- beq (0111): zero = 1 → pc_write = 1, pc_src = 1 in BRANCH. zero = 0 → pc_write = 0. bne (1000) gives the inverse.
- opcode 1010: DECODE → HALT, illegal = 1, retired unchanged, held for 10+ cycles with all enables 0.
- Preload retired to all-ones (2^CNT_W − 1 instructions): one more retire → retired = 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the MiniMIPS multi-cycle sequencer:
// opcodes, ALU op codes, FSM state codes and the control bundle.
package multicycle_control_pkg;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SLTI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_R     = 4'd8;
  localparam logic [3:0] S_WB_I     = 4'd9;
  localparam logic [3:0] S_WB_MEM   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       imem_read;
    logic       dmem_read;
    logic       dmem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic [2:0] imm_alu_op(
    input logic [3:0] op
  );
    logic [2:0] r;
    r = ALU_ADD;
    if (op == OP_ANDI) r = ALU_AND;
    if (op == OP_ORI)  r = ALU_OR;
    if (op == OP_SLTI) r = ALU_SLT;
    return r;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath <-> sequencer bundle: status and memory handshake in,
// enables/selects, debug state, illegal flag and retire count out.
interface multicycle_control_if #(
  parameter int CNT_W = 16
) ();
  logic             run;
  logic [3:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             ir_write;
  logic             imem_read;
  logic             dmem_read;
  logic             dmem_write;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src;
  logic             mem_to_reg;
  logic [2:0]       alu_op;
  logic [3:0]       state_o;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write,
    output imem_read, dmem_read, dmem_write,
    output reg_write, reg_dst, alu_src,
    output mem_to_reg, alu_op,
    output state_o, illegal, retired
  );

  modport slave (
    output run, opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write,
    input  imem_read, dmem_read, dmem_write,
    input  reg_write, reg_dst, alu_src,
    input  mem_to_reg, alu_op,
    input  state_o, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational map of state/opcode/zero/mem_ready to the control
// vector. Moore except FETCH PC/IR load and BRANCH pc_write.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic take;

  assign take = (opcode == OP_BEQ &&  zero) ||
                (opcode == OP_BNE && !zero);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.imem_read = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_op = ALU_ADD;
      S_EXEC_R, S_WB_R: begin
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.reg_write = (state == S_WB_R);
        ctrl.reg_dst   = (state == S_WB_R);
      end
      S_EXEC_I, S_WB_I: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = imm_alu_op(opcode);
        ctrl.reg_write = (state == S_WB_I);
      end
      S_MEM_ADDR, S_MEM_RD, S_MEM_WR: begin
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.dmem_read  = (state == S_MEM_RD);
        ctrl.dmem_write = (state == S_MEM_WR);
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_op   = ALU_SUB;
        ctrl.pc_src   = 1'b1;
        ctrl.pc_write = take;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MiniMIPS sequencer: FSM next-state, sticky illegal
// flag and wrapping retire counter; controls come from the decoder.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multicycle_control_if.master bus
);

  logic [3:0]       state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  ctrl_t            ctrl;

  logic is_r, is_i, is_mem, is_br, is_halt;

  assign is_r    = bus.opcode == OP_R;
  assign is_i    = bus.opcode == OP_ADDI ||
                   bus.opcode == OP_ANDI ||
                   bus.opcode == OP_ORI  ||
                   bus.opcode == OP_SLTI;
  assign is_mem  = bus.opcode == OP_LW ||
                   bus.opcode == OP_SW;
  assign is_br   = bus.opcode == OP_BEQ ||
                   bus.opcode == OP_BNE;
  assign is_halt = bus.opcode == OP_HALT;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    unique case (state_q)
      S_IDLE:
        if (bus.run) state_d = S_FETCH;
      S_FETCH:
        if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_d = S_EXEC_R;
          is_i:    state_d = S_EXEC_I;
          is_mem:  state_d = S_MEM_ADDR;
          is_br:   state_d = S_BRANCH;
          is_halt: state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_MEM_ADDR:
        state_d = (bus.opcode == OP_LW) ? S_MEM_RD
                                        : S_MEM_WR;
      S_MEM_RD:
        if (bus.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  multicycle_control_decode u_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.pc_write   = ctrl.pc_write;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.imem_read  = ctrl.imem_read;
  assign bus.dmem_read  = ctrl.dmem_read;
  assign bus.dmem_write = ctrl.dmem_write;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.alu_src    = ctrl.alu_src;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.state_o    = state_q;
  assign bus.illegal    = illegal_q;
  assign bus.retired    = retired_q;

endmodule
